// File: rtl/cond_logic.sv
// Conditional-execution stage: holds the NZCV flags, evaluates the condition
// field, gates the write strobes and counts executed/squashed instructions.
module cond_logic #(
    parameter int CNT_W   = 16,
    parameter bit NV_PASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             Stall,
    input  logic             CntClr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
);

    logic [3:0] flags_reg;
    logic [3:0] flags_next;
    logic       cond_ex;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       flag_wr;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_reg;

    // Evaluated only against the stored flags; the ALU result of the
    // current instruction cannot influence its own condition.
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'h0:    cond_ex = flag_z;
            4'h1:    cond_ex = !flag_z;
            4'h2:    cond_ex = flag_c;
            4'h3:    cond_ex = !flag_c;
            4'h4:    cond_ex = flag_n;
            4'h5:    cond_ex = !flag_n;
            4'h6:    cond_ex = flag_v;
            4'h7:    cond_ex = !flag_v;
            4'h8:    cond_ex = flag_c && !flag_z;
            4'h9:    cond_ex = !flag_c || flag_z;
            4'hA:    cond_ex = (flag_n == flag_v);
            4'hB:    cond_ex = (flag_n != flag_v);
            4'hC:    cond_ex = !flag_z && (flag_n == flag_v);
            4'hD:    cond_ex = flag_z || (flag_n != flag_v);
            4'hE:    cond_ex = 1'b1;
            default: cond_ex = NV_PASS;
        endcase
    end

    assign CondEx   = cond_ex;
    assign PCSrc    = PCS  && cond_ex && !Stall;
    assign RegWrite = RegW && cond_ex && !Stall;
    assign MemWrite = MemW && cond_ex && !Stall;
    assign Flags    = flags_reg;

    assign flag_wr = cond_ex && !Stall;

    // Half 1 is {N,Z}, half 0 is {C,V}; each has its own FlagW enable.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_flag_half
            assign flags_next[2*gi+1 -: 2] = (flag_wr && FlagW[gi])
                                           ? ALUFlags[2*gi+1 -: 2]
                                           : flags_reg[2*gi+1 -: 2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_reg <= 4'b0000;
        end else begin
            flags_reg <= flags_next;
        end
    end

    // Counter 0 tracks executed instructions, counter 1 squashed ones.
    logic [1:0][CNT_W-1:0] cnt_q;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic             cnt_hit;

            assign cnt_hit = (gi == 0) ? cond_ex : !cond_ex;

            always_ff @(posedge clk) begin
                if (!rst_n || CntClr) begin
                    cnt_reg <= '0;
                end else if (!Stall && cnt_hit && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign cnt_q[gi] = cnt_reg;
        end
    endgenerate

    assign ExecCount   = cnt_q[0];
    assign SquashCount = cnt_q[1];

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios followed by random
// traffic, compared against a behavioural model of the flag/counter rules.
module tb_cond_logic;

    localparam int CNT_W   = 4;
    localparam bit NV_PASS = 1'b0;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       cond;
    logic [3:0]       alu_flags;
    logic [1:0]       flag_w;
    logic             pcs, reg_w, mem_w, stall, cnt_clr;
    logic             pc_src, reg_write, mem_write, cond_ex;
    logic [3:0]       flags;
    logic [CNT_W-1:0] exec_count, squash_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [3:0] m_flags;
    int         m_exec;
    int         m_squash;

    cond_logic #(.CNT_W(CNT_W), .NV_PASS(NV_PASS)) dut (
        .clk(clk), .rst_n(rst_n), .Cond(cond), .ALUFlags(alu_flags),
        .FlagW(flag_w), .PCS(pcs), .RegW(reg_w), .MemW(mem_w),
        .Stall(stall), .CntClr(cnt_clr), .PCSrc(pc_src), .RegWrite(reg_write),
        .MemWrite(mem_write), .CondEx(cond_ex), .Flags(flags),
        .ExecCount(exec_count), .SquashCount(squash_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Conditions come in complementary pairs: odd codes negate the even code below.
    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return NV_PASS;
        case (c >> 1)
            0:       base = z;
            1:       base = cy;
            2:       base = n;
            3:       base = v;
            4:       base = cy && !z;
            5:       base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    // One clock with the inputs currently applied; checks combinational
    // outputs before the edge and registered state after it.
    task automatic cycle(input bit do_comb);
        bit exp_ce;
        #1;
        exp_ce = ref_cond(cond, m_flags);
        if (do_comb) begin
            check("CondEx",   32'(cond_ex),   32'(exp_ce));
            check("PCSrc",    32'(pc_src),    32'(pcs   && exp_ce && !stall));
            check("RegWrite", 32'(reg_write), 32'(reg_w && exp_ce && !stall));
            check("MemWrite", 32'(mem_write), 32'(mem_w && exp_ce && !stall));
        end
        @(posedge clk);
        if (!rst_n) begin
            m_flags = 4'b0; m_exec = 0; m_squash = 0;
        end else begin
            if (!stall && exp_ce) begin
                if (flag_w[1]) m_flags[3:2] = alu_flags[3:2];
                if (flag_w[0]) m_flags[1:0] = alu_flags[1:0];
            end
            if (cnt_clr) begin
                m_exec = 0; m_squash = 0;
            end else if (!stall) begin
                if (exp_ce) m_exec   = (m_exec   < CNT_MAX) ? m_exec + 1   : m_exec;
                else        m_squash = (m_squash < CNT_MAX) ? m_squash + 1 : m_squash;
            end
        end
        #1;
        check("Flags",       32'(flags),        32'(m_flags));
        check("ExecCount",   32'(exec_count),   32'(m_exec));
        check("SquashCount", 32'(squash_count), 32'(m_squash));
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                         input logic p, input logic r, input logic m, input logic s, input logic cc);
        cond = c; alu_flags = af; flag_w = fw; pcs = p; reg_w = r; mem_w = m;
        stall = s; cnt_clr = cc;
    endtask

    task automatic set_flags(input logic [3:0] f);
        drive(4'hE, f, 2'b11, 0, 0, 0, 0, 0);
        cycle(1);
    endtask

    initial begin
        m_flags = 'x; m_exec = 0; m_squash = 0;
        rst_n = 1'b0;
        drive(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        cycle(0);
        cycle(1);
        rst_n = 1'b1;

        // EQ with Z=0 squashes
        drive(4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0);
        cycle(1);
        check("squash_after_eq", 32'(squash_count), 32'd1);

        // AL writes flags, then EQ passes
        drive(4'hE, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
        cycle(1);
        check("flags_z_set", 32'(flags), 32'b0100);
        drive(4'h0, 4'h0, 2'b00, 0, 0, 1, 0, 0);
        cycle(1);

        // Split writes
        set_flags(4'b1010);
        drive(4'hE, 4'b0101, 2'b01, 0, 0, 0, 0, 0);
        cycle(1);
        check("split_cv", 32'(flags), 32'b1001);
        drive(4'hE, 4'b0100, 2'b10, 0, 0, 0, 0, 0);
        cycle(1);
        check("split_nz", 32'(flags), 32'b0101);

        // Signed compares with N=1, V=0
        set_flags(4'b1000);
        for (int c = 4'hA; c <= 4'hD; c++) begin
            drive(4'(c), 4'h0, 2'b00, 1, 1, 1, 0, 0);
            cycle(1);
        end
        // Unsigned compares with C=1, Z=0
        set_flags(4'b0010);
        for (int c = 4'h8; c <= 4'h9; c++) begin
            drive(4'(c), 4'h0, 2'b00, 1, 1, 1, 0, 0);
            cycle(1);
        end
        // Failed LS must not touch the flags
        drive(4'h9, 4'hF, 2'b11, 0, 0, 0, 0, 0);
        cycle(1);
        check("failed_cond_no_write", 32'(flags), 32'b0010);

        // Stall freezes everything, release applies the update
        drive(4'hE, 4'hF, 2'b11, 1, 0, 0, 1, 0);
        cycle(1);
        check("stall_hold_flags", 32'(flags), 32'b0010);
        drive(4'hE, 4'hF, 2'b11, 1, 0, 0, 0, 0);
        cycle(1);
        check("release_update", 32'(flags), 32'hF);

        // Cond=F with NV_PASS=0 never executes
        drive(4'hF, 4'h0, 2'b11, 1, 1, 1, 0, 0);
        cycle(1);

        // Saturation of ExecCount
        drive(4'hE, 4'hF, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1);
        check("exec_saturated", 32'(exec_count), 32'hF);

        // CntClr wins over Stall
        drive(4'hE, 4'h0, 2'b11, 0, 0, 0, 1, 1);
        cycle(1);
        check("clr_with_stall", 32'({exec_count, squash_count}), 32'h0);

        // Reset with CntClr also discards the flag write
        drive(4'hE, 4'hF, 2'b00, 0, 0, 0, 0, 0);
        cycle(1);
        rst_n = 1'b0;
        drive(4'hE, 4'h5, 2'b11, 0, 0, 0, 0, 1);
        cycle(1);
        check("reset_flags", 32'(flags), 32'h0);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            drive(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
            cycle(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
